// File: rtl/o_serdes_if.sv
// Parallel-word handshake and serial output bundle for o_serdes.
// Signal names match the original flat ports so existing fabric code maps directly.
interface o_serdes_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] D;
    logic             DATA_VALID;
    logic             DATA_READY;
    logic             EN;
    logic             FIFO_RST;
    logic             OE_IN;
    logic             Q;
    logic             OE_OUT;
    logic             WORD_START;
    logic             UNDERFLOW;

    modport master (
        output D, DATA_VALID, EN, FIFO_RST, OE_IN,
        input  DATA_READY, Q, OE_OUT, WORD_START, UNDERFLOW
    );

    modport slave (
        input  D, DATA_VALID, EN, FIFO_RST, OE_IN,
        output DATA_READY, Q, OE_OUT, WORD_START, UNDERFLOW
    );
endinterface

// File: rtl/o_serdes.sv
// Transmit serializer: 4-deep word FIFO feeding an MSB-first shifter, one bit per CLK_IN.
// Words are chained gap-free; a break in the stream while EN=1 pulses UNDERFLOW.
module o_serdes #(
    parameter int   WIDTH    = 4,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic     CLK_IN,
    input  logic     RST,
    o_serdes_if.slave bus
);
    localparam int               CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_MAX   = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};

    if (!(WIDTH == 3 || WIDTH == 4 || WIDTH == 6 || WIDTH == 7 ||
          WIDTH == 8 || WIDTH == 9 || WIDTH == 10)) begin : g_width_check
        $error("o_serdes: unsupported WIDTH %0d", WIDTH);
    end

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [4];
    logic [1:0]       wp, rp;
    logic [2:0]       count;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             word_start, word_start_nxt;
    logic             underflow, underflow_nxt;
    logic             oe_out;
    logic             push, pop, avail;

    // FIFO_RST hides the queued words from the load decision in the same cycle it clears them.
    assign bus.DATA_READY = (count < 3'd4);
    assign push           = bus.DATA_VALID && bus.DATA_READY && !bus.FIFO_RST;
    assign avail          = (count != 3'd0) && !bus.FIFO_RST;

    assign bus.Q          = sr[WIDTH-1];
    assign bus.OE_OUT     = oe_out;
    assign bus.WORD_START = word_start;
    assign bus.UNDERFLOW  = underflow;

    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        cnt_nxt        = cnt;
        word_start_nxt = 1'b0;
        underflow_nxt  = 1'b0;
        pop            = 1'b0;
        if (state == SHIFT && cnt != '0) begin
            sr_nxt  = {sr[WIDTH-2:0], IDLE_BIT};
            cnt_nxt = cnt - 1'b1;
        end else if (bus.EN && avail) begin
            pop            = 1'b1;
            sr_nxt         = mem[rp];
            cnt_nxt        = CNT_MAX;
            word_start_nxt = 1'b1;
            state_nxt      = SHIFT;
        end else begin
            underflow_nxt = (state == SHIFT) && bus.EN;
            sr_nxt        = IDLE_WORD;
            cnt_nxt       = '0;
            state_nxt     = IDLE;
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            sr         <= IDLE_WORD;
            cnt        <= '0;
            word_start <= 1'b0;
            underflow  <= 1'b0;
            oe_out     <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            cnt        <= cnt_nxt;
            word_start <= word_start_nxt;
            underflow  <= underflow_nxt;
            oe_out     <= bus.OE_IN;
        end
    end

    always_ff @(posedge CLK_IN or posedge RST) begin
        if (RST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (bus.FIFO_RST) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (push) mem[wp] <= bus.D;
    end
endmodule

// File: doc/o_serdes.md
# o_serdes

Transmit-side serializer that is the counterpart of the input deserializer. It accepts WIDTH-bit parallel words through a valid/ready handshake into a 4-deep word FIFO and shifts them out MSB-first, one bit per CLK_IN cycle, on Q. Words are sent back-to-back without gaps, an underflow is flagged when the stream breaks, and output enable is registered alongside the data. It sits between fabric logic and the I/O pad driver.

## Interface
- WIDTH, 4: word width in bits; legal values are 3, 4, 6, 7, 8, 9 and 10; any other value raises $error at elaboration.
- IDLE_BIT, 1'b0: value driven on Q when no word is being shifted.
- CLK_IN  input  1  serial bit clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- FIFO_RST  input  1  synchronous clear of the word FIFO.
- D  input  WIDTH  parallel word to transmit.
- DATA_VALID  input  1  D is valid this cycle.
- DATA_READY  output  1  FIFO can accept a word; equals (fifo_count < 4).
- EN  input  1  permits loading a new word into the shifter.
- OE_IN  input  1  output-enable request.
- Q  output  1  serial data; equals the shifter MSB.
- OE_OUT  output  1  OE_IN delayed by one cycle.
- WORD_START  output  1  high during the cycle in which Q carries the MSB of a newly loaded word.
- UNDERFLOW  output  1  single-cycle pulse when the stream breaks while EN=1.

## Operation
- Push: a word is written when DATA_VALID && DATA_READY at a rising edge. DATA_READY depends only on the registered count, so a same-cycle pop does not raise it.
- FIFO: 4 entries with 2-bit read/write pointers that wrap from 3 to 0, plus a 3-bit count (0..4). A simultaneous push and pop leaves the count unchanged.
- Shifter: register sr[WIDTH-1:0] and bit counter cnt (0..WIDTH-1); Q = sr[WIDTH-1].
- State IDLE: sr is all IDLE_BIT.
  - On an edge where EN=1 and count>0, pop the FIFO head into sr, set cnt=WIDTH-1, set WORD_START=1 and go to SHIFT.
- State SHIFT, on each edge:
  - If cnt>0: sr <= {sr[WIDTH-2:0], IDLE_BIT}, cnt <= cnt-1.
  - If cnt==0 and EN=1 and count>0: load the next word exactly as from IDLE. Transmission is gap-free.
  - If cnt==0 and EN=1 and count==0: UNDERFLOW=1 for one cycle, go to IDLE.
  - If cnt==0 and EN=0: go to IDLE; UNDERFLOW stays 0.
- EN deasserted mid-word never truncates the word. EN is sampled only at the load decision.
- FIFO_RST: count and both pointers go to 0, and a push in the same cycle is discarded. The word already in sr completes normally.
- A push into an empty FIFO in the same cycle as a load decision is not loaded on that edge; it is loaded at the next decision point.
- WORD_START and UNDERFLOW are registered and are 0 in every other cycle.

## Timing
- Reset (async assert, sync release): state=IDLE, sr=all IDLE_BIT, so Q=IDLE_BIT. Also cnt=0, FIFO count=0 and pointers=0, DATA_READY=1, OE_OUT=0, WORD_START=0, UNDERFLOW=0.
- RST asserted mid-word aborts the word immediately (asynchronously), and Q returns to IDLE_BIT.
- Latency: push accepted at edge t into an idle, empty shifter with EN=1 → word loaded at edge t+1. MSB appears on Q and WORD_START=1 in the cycle after t+1; the LSB is on Q in the cycle after t+WIDTH.
- Back-to-back: the next word's MSB follows the previous LSB in the very next cycle, so there are WIDTH cycles per word.
- Sustained throughput: one word per WIDTH cycles. The FIFO absorbs bursts of up to 4 words.
- OE_OUT at cycle n equals OE_IN at cycle n-1, independent of the data state.

## Test plan
- WIDTH=4, EN=1, push 4'b1011 at edge 0 → Q=1,0,1,1 in the cycles after edges 1..4. WORD_START=1 only after edge 1. Q=IDLE_BIT after edge 5. UNDERFLOW pulses after edge 5.
- Push 4'hA then 4'h5 on consecutive cycles, EN=1 → 8 contiguous bits 1010_0101 on Q. WORD_START pulses 4 cycles apart. UNDERFLOW asserts only after the last bit.
- EN=0, push 5 words with DATA_VALID held high → first 4 accepted, DATA_READY=0 after the 4th, 5th word held. Raising EN drains the 4 words in order; DATA_READY returns to 1 on the edge of the first pop.
- Deassert EN in the middle of word 1 with word 2 queued → word 1 completes, Q goes to IDLE_BIT, no UNDERFLOW, word 2 stays in the FIFO (count=1).
- Assert RST during the 2nd bit of a word → Q=IDLE_BIT immediately, FIFO emptied, DATA_READY=1, OE_OUT=0. Assert FIFO_RST with 3 words queued mid-word → the current word completes, the 3 queued words are never sent, and FIFO_RST does not suppress UNDERFLOW (UNDERFLOW pulses after the last bit if EN=1).
- WIDTH=10, push 10'h2C5 → bits 1011000101 on Q, MSB first. Toggle OE_IN → OE_OUT follows with 1-cycle delay. WIDTH=5 → elaboration $error.
